// File: rtl/tile_pkg.sv
// Shared tile-map definitions: tile codes, map/screen geometry, and the
// access-controller state encoding used by the tile map, renderer and controller.
package tile_pkg;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'b00,
    TILE_FLOOR = 2'b01,
    TILE_GIFT  = 2'b10,
    TILE_EXIT  = 2'b11
  } tile_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOOKUP = 2'b01,
    ST_COMMIT = 2'b10
  } ctrl_state_t;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } hit_t;

  localparam int MAP_COLS        = 8;
  localparam int MAP_ROWS        = 6;
  localparam int TILE_WIDTH      = 80;
  localparam int TILE_HEIGHT     = 80;
  localparam int SCREEN_H_ACTIVE = 640;
  localparam int SCREEN_V_ACTIVE = 480;
  localparam int HIT_FIFO_DEPTH  = 4;

  // Pixel -> tile index by comparing against constant multiples of the tile size.
  function automatic logic [2:0] tile_index(input logic [10:0] pos, input int size, input int count);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if ((i < count) && ({21'd0, pos} >= 32'(i * size))) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tile_hit_fifo.sv
// Small synchronous FIFO holding pending {x,y} gift hits; flush empties it in one cycle.
module tile_hit_fifo
  import tile_pkg::*;
#(
  parameter int DEPTH = HIT_FIFO_DEPTH
) (
  input  logic clk,
  input  logic resetN,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  hit_t wdata,
  output hit_t head,
  output logic empty,
  output logic full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  hit_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // Storage, wrapping pointers and occupancy
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/tile_access_ctrl.sv
// Owns the tile map address port: the renderer reads during active video, queued
// gift hits are serviced as read-modify-write (10 -> 00) during blanking.
module tile_access_ctrl #(
  parameter int FIFO_DEPTH = tile_pkg::HIT_FIFO_DEPTH,
  parameter int TILE_W     = tile_pkg::TILE_WIDTH,
  parameter int TILE_H     = tile_pkg::TILE_HEIGHT,
  parameter int H_ACTIVE   = tile_pkg::SCREEN_H_ACTIVE,
  parameter int V_ACTIVE   = tile_pkg::SCREEN_V_ACTIVE
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        hitReq,
  input  logic [2:0]  hitX,
  input  logic [2:0]  hitY,
  input  logic        EndGame,
  input  logic [1:0]  Tile_Type,
  output logic [2:0]  Xnum,
  output logic [2:0]  Ynum,
  output logic        writeEn,
  output logic [1:0]  information,
  output logic [1:0]  renderTile,
  output logic        renderValid,
  output logic        giftCollected,
  output logic        hitDropped,
  output logic        fifoFull
);

  import tile_pkg::*;

  ctrl_state_t r_state;
  tile_t       r_type;
  logic [1:0]  r_render_tile;
  logic        r_render_valid;
  logic        r_hit_dropped;

  hit_t w_head;
  hit_t w_wdata;
  logic w_active;
  logic w_blank;
  logic w_empty;
  logic w_full;
  logic w_hit_ok;
  logic w_push;
  logic w_pop;
  logic w_gift_write;

  assign w_active = (pixelX < 11'(H_ACTIVE)) && (pixelY < 11'(V_ACTIVE));
  assign w_blank  = !w_active;

  // EndGame masks new hits entirely: no push and no drop report.
  assign w_hit_ok     = hitReq && !EndGame && (hitY <= 3'(MAP_ROWS - 1));
  assign w_pop        = (r_state == ST_COMMIT) && w_blank && !EndGame;
  assign w_push       = w_hit_ok && (!w_full || w_pop);
  assign w_gift_write = w_pop && (r_type == TILE_GIFT);
  assign w_wdata      = '{x: hitX, y: hitY};

  tile_hit_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_hit_fifo (
    .clk   (clk),
    .resetN(resetN),
    .push  (w_push),
    .pop   (w_pop),
    .flush (EndGame),
    .wdata (w_wdata),
    .head  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  // Hit-service sequencer; any return to active video abandons the attempt, head kept
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
      r_type  <= TILE_EMPTY;
    end else if (EndGame) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty && w_blank) begin
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_active) begin
            r_state <= ST_IDLE;
          end else begin
            r_type  <= tile_t'(Tile_Type);
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Map port mux: renderer wins whenever the pixel is active
  always_comb begin
    Xnum          = 3'd0;
    Ynum          = 3'd0;
    writeEn       = 1'b0;
    giftCollected = 1'b0;
    if (!resetN) begin
      Xnum = 3'd0;
      Ynum = 3'd0;
    end else if (w_active) begin
      Xnum = tile_index(pixelX, TILE_W, MAP_COLS);
      Ynum = tile_index(pixelY, TILE_H, MAP_ROWS);
    end else if ((r_state == ST_LOOKUP) || (r_state == ST_COMMIT)) begin
      Xnum          = w_head.x;
      Ynum          = w_head.y;
      writeEn       = w_gift_write;
      giftCollected = w_gift_write;
    end else begin
      Xnum = 3'd0;
      Ynum = 3'd0;
    end
  end

  // Render pipeline and drop pulse
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_render_tile  <= 2'b00;
      r_render_valid <= 1'b0;
      r_hit_dropped  <= 1'b0;
    end else begin
      r_render_tile  <= w_active ? Tile_Type : 2'b00;
      r_render_valid <= w_active;
      r_hit_dropped  <= hitReq && !EndGame && !w_push;
    end
  end

  assign information = 2'b00;
  assign renderTile  = r_render_tile;
  assign renderValid = r_render_valid;
  assign hitDropped  = r_hit_dropped;
  assign fifoFull    = w_full;

endmodule
